// File: rtl/vram_pkg.sv
// vram_pkg -- shared constants and types for the text-VRAM arbiter.
//   AW, DW          : VRAM address / data widths ({row[4:0], col[5:0]}, 8-bit chars)
//   REQ_*           : requester indices; the lowest index has the highest priority
//   state_t         : arbiter FSM encoding
package vram_pkg;

  localparam int AW = 11;
  localparam int DW = 8;

  localparam int REQ_CLEAR  = 0;
  localparam int REQ_SCROLL = 1;
  localparam int REQ_WRITE  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe -- READ_LAT-deep delay line of {valid, requester index}.
// A tag enters on every granted read and leaves READ_LAT cycles later,
// lined up with the VRAM read data.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push         : a granted read is issued this cycle
//   i_idx          : index of the requester issuing it
//   o_rvalid       : one-hot read-valid for the tag at the tail
//   o_nonempty     : at least one read is in flight
module rd_tag_pipe #(
  parameter int N_REQ    = 3,
  parameter int IW       = 2,
  parameter int READ_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [IW-1:0]    i_idx,
  output logic [N_REQ-1:0] o_rvalid,
  output logic             o_nonempty
);

  logic [READ_LAT-1:0] r_vld;
  logic [IW-1:0]       r_idx [READ_LAT];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < READ_LAT; i++) r_idx[i] <= '0;
    end else begin
      r_vld[0] <= i_push;
      r_idx[0] <= i_idx;
      for (int i = 1; i < READ_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  always_comb begin
    o_rvalid = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_vld[READ_LAT-1] && (r_idx[READ_LAT-1] == IW'(k))) o_rvalid[k] = 1'b1;
    end
  end

  assign o_nonempty = |r_vld;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter -- shares the single text-VRAM port between the clear engine,
// scroll engine and char writer with a req/gnt handshake. Fixed priority on
// entry, no preemption, one idle turnaround cycle between owners, and read
// data tagged so only the issuing requester sees o_rvalid.
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_req / o_gnt            : per-requester level request, one-hot grant
//   i_addr, i_din            : packed per-requester address / write data
//   i_ce, i_w                : per-requester enable and write strobe
//   o_rdata, o_rvalid        : broadcast read data, one-hot tagged valid
//   o_vram_*, i_vram_dout    : shared VRAM port
//   o_busy                   : grant held or read in flight
//   o_viol                   : sticky, ce seen from a requester without grant
//
// state | meaning
// IDLE  | no owner; lowest-index active request is latched as owner
// GRANT | owner register valid, owner's slice drives the VRAM port
// DRAIN | owner released, waiting for in-flight reads to return
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int AW       = vram_pkg::AW,
  parameter int DW       = vram_pkg::DW,
  parameter int READ_LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]    i_req,
  output logic [N_REQ-1:0]    o_gnt,
  input  logic [N_REQ*AW-1:0] i_addr,
  input  logic [N_REQ*DW-1:0] i_din,
  input  logic [N_REQ-1:0]    i_ce,
  input  logic [N_REQ-1:0]    i_w,
  output logic [DW-1:0]       o_rdata,
  output logic [N_REQ-1:0]    o_rvalid,
  output logic [AW-1:0]       o_vram_addr,
  output logic [DW-1:0]       o_vram_din,
  output logic                o_vram_ce,
  output logic                o_vram_w,
  input  logic [DW-1:0]       i_vram_dout,
  output logic                o_busy,
  output logic                o_viol
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    w_owner_nxt;
  logic             r_viol;
  logic [N_REQ-1:0] w_gnt;
  logic [IW-1:0]    w_first;
  logic             w_any_req;
  logic             w_owner_req;
  logic             w_push;
  logic             w_pipe_busy;

  // Descending scan so the lowest active index is the one left standing.
  always_comb begin
    w_first   = '0;
    w_any_req = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        w_first   = IW'(k);
        w_any_req = 1'b1;
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_gnt[k] = (r_state == GRANT) && (r_owner == IW'(k));
    end
  end

  // Port mux follows the grant combinationally; with no owner the shared
  // port is parked at zero so a reset or release kills the access at once.
  always_comb begin
    o_vram_addr = '0;
    o_vram_din  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt[k]) begin
        o_vram_addr = i_addr[k*AW +: AW];
        o_vram_din  = i_din[k*DW +: DW];
      end
    end
  end

  assign o_vram_ce   = |(w_gnt & i_ce);
  assign o_vram_w    = |(w_gnt & i_w);
  assign w_push      = |(w_gnt & i_ce & ~i_w);
  assign w_owner_req = |(w_gnt & i_req);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = GRANT;
          w_owner_nxt = w_first;
        end
      end
      GRANT: begin
        // A read issued in the release cycle still counts as in flight.
        if (!w_owner_req) w_state_nxt = (w_pipe_busy || w_push) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (!w_pipe_busy) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_viol  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_viol  <= r_viol | (|(i_ce & ~w_gnt));
    end
  end

  rd_tag_pipe #(
    .N_REQ    (N_REQ),
    .IW       (IW),
    .READ_LAT (READ_LAT)
  ) u_rd_tag_pipe (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_push),
    .i_idx      (r_owner),
    .o_rvalid   (o_rvalid),
    .o_nonempty (w_pipe_busy)
  );

  assign o_gnt   = w_gnt;
  assign o_rdata = i_vram_dout;
  assign o_busy  = (r_state != IDLE) | w_pipe_busy;
  assign o_viol  = r_viol;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single text-VRAM write/read port between three requesters: clear engine (0), scroll engine (1) and char writer (2).
- Replaces the status-decoded combinational mux in the terminal controller with an explicit req/gnt handshake, which makes the VRAM engines independent of the control FSM.
- Sits between the controller's engines and the text/VRAM block.
- Tags each read so only the issuing requester sees o_rvalid.

Parameters:
- N_REQ, 3, number of requesters; index 0 has highest priority.
- AW, 11, VRAM address width ({row[4:0], col[5:0]}).
- DW, 8, VRAM data width.
- READ_LAT, 1, cycles from a granted read (ce=1, w=0) to valid i_vram_dout; legal range 1..3.

Ports:
- i_clk  in  1  system clock, 12 MHz.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  N_REQ  per-requester bus request, level; held for the whole transaction burst.
- o_gnt  out  N_REQ  one-hot grant, or all zero.
- i_addr  in  N_REQ*AW  packed addresses; slice k belongs to requester k.
- i_din  in  N_REQ*DW  packed write data.
- i_ce  in  N_REQ  per-requester clock enable.
- i_w  in  N_REQ  per-requester write strobe (1 = write, 0 = read).
- o_rdata  out  DW  i_vram_dout broadcast to all requesters.
- o_rvalid  out  N_REQ  one-hot; read data valid for the requester that issued the read.
- o_vram_addr  out  AW  shared VRAM address.
- o_vram_din  out  DW  shared VRAM write data.
- o_vram_ce  out  1  shared VRAM clock enable.
- o_vram_w  out  1  shared VRAM write enable.
- i_vram_dout  in  DW  VRAM read data.
- o_busy  out  1  high whenever any grant is held or a read is in flight.
- o_viol  out  1  sticky: a requester drove ce without holding a grant.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, o_gnt=0, o_vram_ce=0, o_vram_w=0, o_vram_addr=0, o_vram_din=0, o_rvalid=0, read tag pipe cleared, o_busy=0, o_viol=0. Reset mid-burst aborts with no further VRAM access.
- FSM states:
  - IDLE: no owner.
  - GRANT: owner register valid.
  - DRAIN: owner released, reads still in flight.
- IDLE: if any i_req is high, latch the lowest-index requester as owner and go to GRANT; o_gnt rises the next cycle. Latency from req to gnt is 1 cycle.
- GRANT: o_gnt = onehot(owner). The VRAM outputs mux the owner's slice combinationally: ce and w are gated by gnt, address and data pass through. Non-owner ce/w are ignored.
- No preemption: the owner keeps the grant while its i_req=1, even if a higher-priority requester asserts.
- Owner drops i_req: o_gnt falls the same edge the FSM samples it (next cycle). Go to DRAIN if the tag pipe is non-empty, else to IDLE.
- DRAIN: wait until the tag pipe empties, then go to IDLE.
- Handover gap: at least one IDLE cycle between consecutive owners (bus turnaround). Back-to-back owners therefore see ≥2 cycles from release to the next gnt.
- Simultaneous requests in IDLE: lowest index wins. A requester that drops req in the same cycle it would be granted is not granted (sampled registered req).
- Read tagging: a shift register READ_LAT deep carries {valid, owner}. Entries are pushed when the granted ce=1 and w=0. At the tail, o_rvalid[tag]=1 for exactly one cycle, aligned with i_vram_dout. Reads complete after the owner releases (DRAIN).
- Writes (ce=1, w=1) take 1 cycle and produce no rvalid.
- o_viol: set when any i_ce[k]=1 while o_gnt[k]=0. Cleared only by reset.
- o_busy = (state != IDLE) | tag pipe non-empty.

Decomposition:
- Shared package vram_pkg: AW, DW, requester index constants REQ_CLEAR=0, REQ_SCROLL=1, REQ_WRITE=2, state encodings IDLE/GRANT/DRAIN.
- One natural sub-module: rd_tag_pipe (parameterised READ_LAT delay line of {valid, idx}, outputs one-hot rvalid and a non-empty flag).

Test Plan:
- Single writer: req[2]=1 at t0 → gnt=3'b100 at t1. Write addr 0x3A5, din 0x41, ce=w=1 at t1 → o_vram_addr=0x3A5, o_vram_din=0x41, o_vram_w=1 that cycle; o_rvalid stays 0.
- Priority contention: i_req=3'b111 from IDLE → gnt=3'b001. Drop req[0] → ≥1 IDLE cycle, then gnt=3'b010. Drop req[1] → gnt=3'b100.
- No preemption: scroll granted, then req[0] rises → gnt stays 3'b010 until req[1] drops; clear is granted 2 cycles later.
- Read tag with READ_LAT=2: scroll reads addr 0x040 at t5 and drops req at t6 → state DRAIN. At t7 o_rvalid=3'b010 with o_rdata equal to the memory model value; IDLE follows.
- Violation: req[2]=0, i_ce[2]=1 → o_vram_ce stays 0, o_viol=1 next cycle and stays high until i_rst_n=0.
- Async reset mid-burst: clear granted and writing, pull i_rst_n low between clock edges → o_gnt=0 and o_vram_ce=0 immediately. After release with req[0] still high, re-grant follows 1 cycle later.
